i2s_transmitter: RTL

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/audio_pkg.sv | 12 +
 rtl/i2s_clkgen.sv | 47 ++++
 rtl/i2s_transmitter.sv | 118 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S output path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package audio_pkg;

   localparam int SAMPLE_W    = 16;  // PCM sample width, two's complement
   localparam int FRAME_BITS  = 32;  // bit slots per stereo frame (16 left + 16 right)
   localparam int CLK_DIV_DEF = 16;  // default core cycles per I2S bit-clock half-period

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides the core clock down to I2S_CLK and flags its falling edges.
// Latency: o_fall is combinational and marks the cycle whose closing edge drops o_i2s_clk.
// Backpressure: none; i_en low parks the divider at 0 with the bit clock low.
//
// Ports:
//   i_clk      core clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_en       run the divider when high
//   o_i2s_clk  registered bit clock
//   o_fall     strobe, high in the cycle in which o_i2s_clk goes 1->0
module i2s_clkgen
   import audio_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_i2s_clk,
   output logic o_fall
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic             r_i2s_clk;
   logic             w_tc;

   assign w_tc = (r_div == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_en) begin
         r_div     <= '0;
         r_i2s_clk <= 1'b0;
      end else if (w_tc) begin
         r_div     <= '0;
         r_i2s_clk <= ~r_i2s_clk;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign o_i2s_clk = r_i2s_clk;
   // Terminal count while the clock is high means the next edge drops it.
   assign o_fall    = i_rst_n && i_en && w_tc && r_i2s_clk;

endmodule

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S serializer with one-deep holding register and per-frame attenuation.
// Latency: a sample accepted before a frame start goes out in that frame; frame = 64*CLK_DIV cycles.
// Backpressure: SampleReady low while the holding register is full; it empties at each frame start.
//
// Ports:
//   CLK, Reset        core clock (rising edge) and synchronous active-low reset
//   Enable            run the serializer; low parks bit clock, WS, data and slot counter
//   Attenuation       arithmetic right-shift applied to the sample at frame start
//   Sample/SampleValid/SampleReady  valid-ready input of mono PCM samples
//   Underrun          one-cycle pulse when a frame starts with nothing held
//   I2S_CLK/I2S_WS/I2S_DATA         I2S bus to the DAC, data MSB first
module i2s_transmitter
   import audio_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Enable,
   input  logic [3:0]          Attenuation,
   input  logic [SAMPLE_W-1:0] Sample,
   input  logic                SampleValid,
   output logic                SampleReady,
   output logic                Underrun,
   output logic                I2S_CLK,
   output logic                I2S_WS,
   output logic                I2S_DATA
);

   localparam int SLOT_W = $clog2(FRAME_BITS);
   localparam int HALF   = FRAME_BITS / 2;

   logic                       w_fall;
   logic                       w_i2s_clk;
   logic                       w_fstart;
   logic                       w_xfer;
   logic [SLOT_W-1:0]          r_slot;
   logic [SLOT_W-1:0]          w_slot_nxt;
   logic                       r_full;
   logic signed [SAMPLE_W-1:0] r_hold;
   logic signed [SAMPLE_W-1:0] r_word;   // sample of the current frame, reused for the right word
   logic signed [SAMPLE_W-1:0] r_shift;  // bits still to send in the current word
   logic signed [SAMPLE_W-1:0] w_shifted;
   logic signed [SAMPLE_W-1:0] w_load;
   logic                       r_ws;
   logic                       r_data;
   logic                       r_underrun;

   i2s_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .i_clk     (CLK),
      .i_rst_n   (Reset),
      .i_en      (Enable),
      .o_i2s_clk (w_i2s_clk),
      .o_fall    (w_fall)
   );

   assign w_slot_nxt = r_slot + 1'b1;
   assign w_fstart   = w_fall && (r_slot == '1);
   assign w_xfer     = SampleValid && !r_full;

   // Kept as its own signed expression so the shift stays arithmetic.
   assign w_shifted  = r_hold >>> Attenuation;
   assign w_load     = r_full ? w_shifted : '0;

   // Holding register: a transfer wins over the frame-start clear, which is
   // only reachable when holding was empty (ready high) in that same cycle.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         r_full <= 1'b0;
         r_hold <= '0;
      end else if (w_xfer) begin
         r_full <= 1'b1;
         r_hold <= Sample;
      end else if (w_fstart) begin
         r_full <= 1'b0;
      end
   end

   // Slot counter and output shifter, all advancing on bit-clock fall events.
   always_ff @(posedge CLK) begin
      if (!Reset || !Enable) begin
         r_slot     <= '1;
         r_ws       <= 1'b0;
         r_data     <= 1'b0;
         r_underrun <= 1'b0;
         r_word     <= '0;
         r_shift    <= '0;
      end else begin
         r_underrun <= w_fstart && !r_full;
         if (w_fall) begin
            r_slot <= w_slot_nxt;
            // WS flips one slot ahead of each word's MSB.
            r_ws   <= (w_slot_nxt >= SLOT_W'(HALF - 1)) && (w_slot_nxt <= SLOT_W'(FRAME_BITS - 2));
            if (w_fstart) begin
               r_word  <= w_load;
               r_shift <= w_load << 1;
               r_data  <= w_load[SAMPLE_W-1];
            end else if (w_slot_nxt == SLOT_W'(HALF)) begin
               r_shift <= r_word << 1;
               r_data  <= r_word[SAMPLE_W-1];
            end else begin
               r_shift <= r_shift << 1;
               r_data  <= r_shift[SAMPLE_W-1];
            end
         end
      end
   end

   assign SampleReady = !r_full;
   assign Underrun    = r_underrun;
   assign I2S_CLK     = w_i2s_clk;
   assign I2S_WS      = r_ws;
   assign I2S_DATA    = r_data;

endmodule
